// File: rtl/ro_sel_mux.sv
// rtl/ro_sel_mux.sv - ring-oscillator channel select mux with blank/settle gating
module ro_sel_mux #(
    parameter int N_CH       = 8,
    parameter int SEL_W      = $clog2(N_CH),
    parameter int SETTLE_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  ro_in,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic             mux_dis,
    output logic             mux_out,
    output logic             active,
    output logic [SEL_W-1:0] cur_sel,
    output logic             sel_err
);

    // A zero settle time still needs a 1-bit counter to keep the declarations legal.
    localparam int              CNT_W       = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
    localparam bit              ZERO_SETTLE = (SETTLE_CYC == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        SETTLE = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] cur_sel_nxt;
    logic             sel_err_nxt;
    logic             accept;
    logic             in_range;

    assign sel_ready = (state == IDLE) || (state == ACTIVE);
    assign accept    = sel_valid && sel_ready && !mux_dis;
    assign in_range  = (32'(sel_in) < 32'(N_CH));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cur_sel_nxt = cur_sel;
        sel_err_nxt = 1'b0;
        if (mux_dis) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE, ACTIVE: begin
                    if (accept) begin
                        if (in_range) begin
                            cur_sel_nxt = sel_in;
                            state_nxt   = BLANK;
                            cnt_nxt     = SETTLE_LOAD;
                        end else begin
                            sel_err_nxt = 1'b1;
                        end
                    end
                end
                BLANK: begin
                    state_nxt = ZERO_SETTLE ? ACTIVE : SETTLE;
                end
                SETTLE: begin
                    // Counter holds the remaining SETTLE cycles including the current one.
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_sel <= '0;
            sel_err <= 1'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_sel <= cur_sel_nxt;
            sel_err <= sel_err_nxt;
            active  <= (state_nxt == ACTIVE);
        end
    end

    // ro_in is asynchronous to clk; it is only gated, never sampled.
    assign mux_out = ro_in[cur_sel] & active;

endmodule

// File: tb/tb_ro_sel_mux.sv
// tb/tb_ro_sel_mux.sv - directed scoreboard bench for ro_sel_mux
module tb_ro_sel_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mux_dis;
    logic [7:0] ro_in;
    logic [2:0] sel_in;
    logic       valid_a, valid_b, valid_c;

    logic       rdy_a, mo_a, act_a, err_a;
    logic [2:0] cs_a;
    logic       rdy_b, mo_b, act_b, err_b;
    logic [2:0] cs_b;
    logic       rdy_c, mo_c, act_c, err_c;
    logic [2:0] cs_c;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ro_sel_mux #(.N_CH(8), .SETTLE_CYC(4)) u_a (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .sel_in(sel_in), .sel_valid(valid_a),
        .sel_ready(rdy_a), .mux_dis(mux_dis), .mux_out(mo_a), .active(act_a),
        .cur_sel(cs_a), .sel_err(err_a)
    );

    ro_sel_mux #(.N_CH(6), .SETTLE_CYC(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in[5:0]), .sel_in(sel_in), .sel_valid(valid_b),
        .sel_ready(rdy_b), .mux_dis(mux_dis), .mux_out(mo_b), .active(act_b),
        .cur_sel(cs_b), .sel_err(err_b)
    );

    ro_sel_mux #(.N_CH(8), .SETTLE_CYC(0)) u_c (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .sel_in(sel_in), .sel_valid(valid_c),
        .sel_ready(rdy_c), .mux_dis(mux_dis), .mux_out(mo_c), .active(act_c),
        .cur_sel(cs_c), .sel_err(err_c)
    );

    function automatic logic get_act(int d);
        return (d == 0) ? act_a : (d == 1) ? act_b : act_c;
    endfunction

    function automatic logic get_rdy(int d);
        return (d == 0) ? rdy_a : (d == 1) ? rdy_b : rdy_c;
    endfunction

    function automatic logic get_mo(int d);
        return (d == 0) ? mo_a : (d == 1) ? mo_b : mo_c;
    endfunction

    function automatic logic [2:0] get_cs(int d);
        return (d == 0) ? cs_a : (d == 1) ? cs_b : cs_c;
    endfunction

    function automatic logic get_err(int d);
        return (d == 0) ? err_a : (d == 1) ? err_b : err_c;
    endfunction

    task automatic set_valid(int d, logic v);
        if (d == 0) valid_a = v;
        else if (d == 1) valid_b = v;
        else valid_c = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string t, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
        end
    endtask

    task automatic sb_pop(string t, logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<scoreboard empty>", t, obs);
        end else begin
            e = exp_q.pop_front();
            chk(t, obs, e);
        end
    endtask

    // Drive an accepted in-range select and follow it through blank/settle to active.
    task automatic do_select(int d, logic [2:0] ch, int s);
        sel_in = ch;
        set_valid(d, 1'b1);
        for (int i = 0; i <= s; i++) exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        step();
        set_valid(d, 1'b0);
        for (int i = 0; i <= s + 1; i++) begin
            if (i > 0) step();
            sb_pop($sformatf("latency_d%0d_ch%0d_c%0d", d, ch, i), get_act(d));
            chk($sformatf("ready_d%0d_c%0d", d, i), get_rdy(d), (i == s + 1));
            if (i <= s) chk($sformatf("gated_d%0d_c%0d", d, i), get_mo(d), 1'b0);
        end
        chk($sformatf("cur_sel_d%0d", d), get_cs(d), ch);
    endtask

    initial begin
        rst_n   = 1'b0;
        mux_dis = 1'b0;
        ro_in   = 8'hFF;
        sel_in  = 3'd0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;

        #2;
        chk("rst_ready", rdy_a, 1'b1);
        chk("rst_active", act_a, 1'b0);
        chk("rst_mux_out", mo_a, 1'b0);
        chk("rst_cur_sel", cs_a, 3'd0);
        chk("rst_sel_err", err_a, 1'b0);
        chk("rst_mux_out_c", mo_c, 1'b0);
        step();
        rst_n = 1'b1;

        // basic select, accepted on the first edge after reset release
        do_select(0, 3'd5, 4);
        for (int v = 0; v < 4; v++) begin
            ro_in[5] = v[0];
            #1;
            chk($sformatf("follow_ro5_%0d", v), mo_a, v[0]);
        end
        ro_in = 8'hFF;

        // re-select, including the same index
        do_select(0, 3'd2, 4);
        do_select(0, 3'd3, 4);
        ro_in = 8'b0000_1000;
        #1 chk("follow_ro3_hi", mo_a, 1'b1);
        ro_in = 8'b1111_0111;
        #1 chk("follow_ro3_lo", mo_a, 1'b0);
        ro_in = 8'hFF;
        do_select(0, 3'd3, 4);

        // requests during blank/settle are dropped
        sel_in  = 3'd4;
        valid_a = 1'b1;
        step();
        sel_in = 3'd1;
        for (int j = 1; j <= 5; j++) begin
            step();
            chk($sformatf("ignore_err_%0d", j), err_a, 1'b0);
            chk($sformatf("ignore_cs_%0d", j), cs_a, 3'd4);
        end
        valid_a = 1'b0;
        chk("ignore_active", act_a, 1'b1);
        step();
        chk("ignore_no_queue", cs_a, 3'd4);

        // disable beats a simultaneous request
        mux_dis = 1'b1;
        valid_a = 1'b1;
        sel_in  = 3'd1;
        step();
        chk("dis_active", act_a, 1'b0);
        chk("dis_ready", rdy_a, 1'b1);
        chk("dis_cur_sel", cs_a, 3'd4);
        chk("dis_sel_err", err_a, 1'b0);
        chk("dis_mux_out", mo_a, 1'b0);
        mux_dis = 1'b0;
        valid_a = 1'b0;
        step();
        chk("dis_stays_idle", act_a, 1'b0);
        chk("dis_no_late_err", err_a, 1'b0);

        // disable mid-settle, then a fresh switch must take the full settle time
        sel_in  = 3'd6;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        step();
        mux_dis = 1'b1;
        step();
        mux_dis = 1'b0;
        chk("dis_settle_active", act_a, 1'b0);
        chk("dis_settle_ready", rdy_a, 1'b1);
        chk("dis_settle_cs", cs_a, 3'd6);
        do_select(0, 3'd1, 4);

        // out-of-range on a 6-channel instance
        for (int k = 6; k <= 7; k++) begin
            sel_in  = 3'(k);
            valid_b = 1'b1;
            step();
            valid_b = 1'b0;
            chk($sformatf("oor_err_%0d", k), err_b, 1'b1);
            chk($sformatf("oor_cs_%0d", k), cs_b, 3'd0);
            chk($sformatf("oor_active_%0d", k), act_b, 1'b0);
            chk($sformatf("oor_ready_%0d", k), rdy_b, 1'b1);
            step();
            chk($sformatf("oor_err_clear_%0d", k), err_b, 1'b0);
        end
        do_select(1, 3'd5, 4);
        sel_in  = 3'd7;
        valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        chk("oor_act_err", err_b, 1'b1);
        chk("oor_act_keep_active", act_b, 1'b1);
        chk("oor_act_keep_cs", cs_b, 3'd5);
        step();
        chk("oor_act_err_clear", err_b, 1'b0);
        chk("oor_act_still_active", act_b, 1'b1);

        // zero settle time
        do_select(2, 3'd0, 0);
        ro_in = 8'hFE;
        #1 chk("zs_follow_lo", mo_c, 1'b0);
        ro_in = 8'h01;
        #1 chk("zs_follow_hi", mo_c, 1'b1);
        ro_in = 8'hFF;
        do_select(2, 3'd7, 0);

        // asynchronous reset in the middle of settle
        sel_in  = 3'd6;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_active", act_a, 1'b0);
        chk("arst_mux_out", mo_a, 1'b0);
        chk("arst_cur_sel", cs_a, 3'd0);
        chk("arst_ready", rdy_a, 1'b1);
        chk("arst_active_c", act_c, 1'b0);
        #1 rst_n = 1'b1;
        step();
        chk("arst_idle_active", act_a, 1'b0);
        chk("arst_idle_cs", cs_a, 3'd0);
        chk("arst_idle_ready", rdy_a, 1'b1);
        for (int j = 0; j < 5; j++) step();
        chk("arst_abandoned", act_a, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
